uart_rx_param: RTL
==================

UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame (legal 5..9).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, receive FIFO entries (power of 2, >=2).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, rx synchroniser flops (>=2).
REQ-004 SHALL have ports: clk in 1 system clock; rst_n in 1 synchronous active-low reset.
REQ-005 SHALL have ports: clk_div in 32 clocks per bit; parity_mode in 2 (00 none, 01 even, 10 odd, 11 none); two_stop in 1 (0 one stop bit, 1 two).
REQ-006 SHALL have ports: rx in 1 serial input (async); rd_en in 1 pop request; err_clr in 1 clears sticky errors.
REQ-007 SHALL have ports: rd_data out DATA_BITS FIFO head; empty out 1; level out $clog2(FIFO_DEPTH)+1 occupancy.
REQ-008 SHALL have ports: irq out 1; frame_err out 1; parity_err out 1; overrun out 1; busy out 1.

Function
REQ-009 SHALL pass rx through SYNC_STAGES flops (reset value 1); all logic uses the synchronised value rxs.
REQ-010 SHALL use effective divisor div = max(clk_div, 2); clk_div changes take effect at next IDLE.
REQ-011 SHALL implement states IDLE, START, DATA, PARITY, STOP, RECOVER.
REQ-012 IDLE: busy=0; rxs==0 -> START, bit counter cleared.
REQ-013 START: after (div>>1) cycles sample rxs; 0 -> DATA, 1 -> IDLE (glitch rejected, no flag, no push).
REQ-014 DATA: sample every div cycles, LSB first, DATA_BITS samples; then PARITY if parity_mode is 01/10, else STOP.
REQ-015 PARITY: sample after div cycles; mismatch (even: XOR of data^parity must be 0; odd: must be 1) marks frame bad-parity.
REQ-016 STOP: sample 1 or 2 stop bits (two_stop), each div cycles apart; any stop sample 0 -> frame error.
REQ-017 Good frame: push data at final stop sample; empty deasserts next cycle; -> IDLE.
REQ-018 Parity-bad frame: no push, parity_err set; -> IDLE.
REQ-019 Frame error: no push, frame_err set; -> RECOVER; RECOVER waits rxs==1 (break tolerance) then -> IDLE.
REQ-020 busy SHALL be 1 in START, DATA, PARITY, STOP, RECOVER.
REQ-021 FIFO full at push with rd_en=0: data dropped, overrun set; full with rd_en=1 same cycle: pop and push both succeed.
REQ-022 rd_data SHALL be show-ahead (valid whenever empty=0); rd_en while empty is ignored, no flag.
REQ-023 level SHALL equal entries held; push+pop same cycle leaves level unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-024 Sticky flags cleared by err_clr pulse; set event in same cycle as err_clr wins.
REQ-025 irq SHALL be registered level: (!empty) | frame_err | parity_err | overrun, updated one cycle after cause.

Reset
REQ-026 On rst_n==0 at clk edge: state IDLE, counters 0, FIFO emptied (empty=1, level=0, rd_data=0), all flags 0, irq=0, busy=0, synchroniser=1.
REQ-027 Reset mid-frame SHALL abandon the frame without push or flag; reception resumes at next falling edge after release.

Structure
REQ-028 Package uart_pkg SHALL hold the state enum, parity_mode encodings and the minimum-divisor constant.
REQ-029 FIFO SHALL be sub-module uart_sync_fifo (params WIDTH, DEPTH; push/pop/full/empty/level, show-ahead).

Verification
REQ-030 clk_div=4, 8N1, send 0xA5 -> rd_data=0xA5, empty falls 1 cycle after final stop sample, irq=1, no flags.
REQ-031 clk_div=4, even parity, send 0x07 with parity bit 0 -> parity_err=1, level stays 0; err_clr -> parity_err=0.
REQ-032 DATA_BITS=8, two_stop=1, second stop bit 0 -> frame_err=1, no push; hold rx low 40 cycles -> busy=1 until rx high, then IDLE.
REQ-033 FIFO_DEPTH=4: send 5 bytes 0x01..0x05 without reads -> level=4, overrun=1, reads return 0x01..0x04; repeat with rd_en at 5th push -> overrun=0, level=4.
REQ-034 rx low pulse of 1 cycle (clk_div=8) -> returns to IDLE, busy drops, no push, no flags.
REQ-035 Assert rst_n=0 during DATA of byte 0x3C -> all outputs reset values; following 0x81 frame received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the parameterised UART receiver.
package uart_pkg;

    // Receiver frame states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_RECOVER
    } state_t;

    // parity_mode encodings (11 behaves as no parity)
    localparam logic [1:0] PAR_NONE  = 2'b00;
    localparam logic [1:0] PAR_EVEN  = 2'b01;
    localparam logic [1:0] PAR_ODD   = 2'b10;
    localparam logic [1:0] PAR_NONE2 = 2'b11;

    // Smallest usable clocks-per-bit; needed so the half-bit start delay is >= 1
    localparam logic [31:0] MIN_DIV = 32'd2;

    // Effective divisor after clamping to the minimum
    function automatic logic [31:0] eff_div(input logic [31:0] d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO; simultaneous push and pop are both honoured when full.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp, r_rp;
    logic [AW:0]      r_level;
    logic             w_pop_ok, w_push_ok;

    // A pop on an empty FIFO is ignored; a push to a full FIFO only lands if a pop frees a slot
    assign w_pop_ok  = i_pop && (r_level != '0);
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    assign o_full  = (r_level == (AW+1)'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_rdata = o_empty ? '0 : r_mem[r_rp];

    // Storage array, no reset needed since the head is masked while empty
    always_ff @(posedge i_clk) begin
        if (w_push_ok) r_mem[r_wp] <= i_wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
        end else begin
            if (w_push_ok) r_wp <= r_wp + 1'b1;
            if (w_pop_ok)  r_rp <= r_rp + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling-free UART receiver: centre-samples each bit using a clocks-per-bit divisor,
// checks optional parity and 1/2 stop bits, and queues good frames in a show-ahead FIFO.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [31:0]                   i_clk_div,
    input  logic [1:0]                    i_parity_mode,
    input  logic                          i_two_stop,
    input  logic                          i_rx,
    input  logic                          i_rd_en,
    input  logic                          i_err_clr,
    output logic [DATA_BITS-1:0]          o_rd_data,
    output logic                          o_empty,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_irq,
    output logic                          o_frame_err,
    output logic                          o_parity_err,
    output logic                          o_overrun,
    output logic                          o_busy
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rxs;
    state_t                 r_state, w_next;
    logic [31:0]            r_div, r_cnt, w_target;
    logic [3:0]             r_bitcnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par_bad, r_stop_idx;
    logic                   w_tick, w_par_en, w_par_mis;
    logic                   w_push, w_set_ferr, w_set_perr, w_full;
    logic                   r_ferr, r_perr, r_ovr, r_irq;

    // Metastability synchroniser; idles high so reset never looks like a start bit
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_sync <= '1;
        else          r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx};
    end
    assign w_rxs = r_sync[SYNC_STAGES-1];

    // START waits half a bit to land mid-bit; every later sample is one full bit apart
    assign w_target  = (r_state == ST_START) ? (r_div >> 1) : r_div;
    assign w_tick    = (r_cnt == w_target - 32'd1);
    assign w_par_en  = (i_parity_mode == PAR_EVEN) || (i_parity_mode == PAR_ODD);
    assign w_par_mis = (i_parity_mode == PAR_EVEN) ? (^{r_shift, w_rxs}) : ~(^{r_shift, w_rxs});

    // Next-state and per-frame outcome decode
    always_comb begin
        w_next     = r_state;
        w_push     = 1'b0;
        w_set_ferr = 1'b0;
        w_set_perr = 1'b0;
        case (r_state)
            ST_IDLE:    if (!w_rxs) w_next = ST_START;
            ST_START:   if (w_tick) w_next = w_rxs ? ST_IDLE : ST_DATA;
            ST_DATA:    if (w_tick && (r_bitcnt == 4'(DATA_BITS-1)))
                            w_next = w_par_en ? ST_PARITY : ST_STOP;
            ST_PARITY:  if (w_tick) w_next = ST_STOP;
            ST_STOP: begin
                if (w_tick) begin
                    if (!w_rxs) begin
                        w_set_ferr = 1'b1;
                        w_next     = ST_RECOVER;
                    end else if (!i_two_stop || r_stop_idx) begin
                        w_next     = ST_IDLE;
                        w_set_perr = r_par_bad;
                        w_push     = !r_par_bad;
                    end
                end
            end
            ST_RECOVER: if (w_rxs) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // State register plus bit timing and data capture
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_div      <= MIN_DIV;
            r_cnt      <= '0;
            r_bitcnt   <= '0;
            r_shift    <= '0;
            r_par_bad  <= 1'b0;
            r_stop_idx <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE || r_state == ST_RECOVER || w_tick) r_cnt <= '0;
            else                                                       r_cnt <= r_cnt + 32'd1;
            if (r_state == ST_IDLE) begin
                r_div      <= eff_div(i_clk_div);
                r_bitcnt   <= '0;
                r_par_bad  <= 1'b0;
                r_stop_idx <= 1'b0;
            end
            if (r_state == ST_DATA && w_tick) begin
                r_shift  <= {w_rxs, r_shift[DATA_BITS-1:1]};
                r_bitcnt <= r_bitcnt + 4'd1;
            end
            if (r_state == ST_PARITY && w_tick) r_par_bad  <= w_par_mis;
            if (r_state == ST_STOP && w_tick)   r_stop_idx <= 1'b1;
        end
    end

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_wdata (r_shift),
        .i_pop   (i_rd_en),
        .o_rdata (o_rd_data),
        .o_full  (w_full),
        .o_empty (o_empty),
        .o_level (o_level)
    );

    // Sticky error flags; a new error in the clearing cycle takes priority; irq lags causes by one cycle
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ferr <= 1'b0;
            r_perr <= 1'b0;
            r_ovr  <= 1'b0;
            r_irq  <= 1'b0;
        end else begin
            r_ferr <= w_set_ferr | (r_ferr & ~i_err_clr);
            r_perr <= w_set_perr | (r_perr & ~i_err_clr);
            r_ovr  <= (w_push & w_full & ~i_rd_en) | (r_ovr & ~i_err_clr);
            r_irq  <= ~o_empty | r_ferr | r_perr | r_ovr;
        end
    end

    assign o_frame_err  = r_ferr;
    assign o_parity_err = r_perr;
    assign o_overrun    = r_ovr;
    assign o_irq        = r_irq;
    assign o_busy       = (r_state != ST_IDLE);

endmodule
